// File: rtl/nios_practica_clkdiv_gen_pkg.sv
// Shared definitions for the multi-channel fabric clock generator.
//   state_t     : top-level FSM state (settling vs. running/locked)
//   chan_cfg_t  : per-channel configuration {en, div, phase}
//   *_DEF       : default parameter values used by the top level
// Channel configuration fields are CFG_DIV_W bits wide; the top-level DIV_W
// parameter must equal CFG_DIV_W so the cfg bus and the stored fields line up.
package nios_practica_clk_pkg;

  localparam int CFG_DIV_W       = 16;
  localparam int DEFAULT_DIV_DEF = 3;
  localparam int LOCK_CYCLES_DEF = 8;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  typedef struct packed {
    logic                 en;
    logic [CFG_DIV_W-1:0] div;
    logic [CFG_DIV_W-1:0] phase;
  } chan_cfg_t;

endpackage

// File: rtl/nios_practica_clkdiv_gen_if.sv
// Configuration bus of the clock generator.
//   cfg_wr    : one-cycle write strobe          (master -> slave)
//   cfg_sel   : target channel                  (master -> slave)
//   cfg_div   : divide ratio N                  (master -> slave)
//   cfg_phase : start position P                (master -> slave)
//   cfg_en    : channel enable                  (master -> slave)
//   cfg_err   : one-cycle reject/clip pulse     (slave -> master)
interface nios_practica_clkdiv_gen_if #(
  parameter int SEL_W = 2,
  parameter int DIV_W = 16
) ();
  logic             cfg_wr;
  logic [SEL_W-1:0] cfg_sel;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic             cfg_en;
  logic             cfg_err;

  modport master (output cfg_wr, cfg_sel, cfg_div, cfg_phase, cfg_en, input cfg_err);
  modport slave  (input cfg_wr, cfg_sel, cfg_div, cfg_phase, cfg_en, output cfg_err);
endinterface

// File: rtl/nios_practica_clkdiv_chan.sv
// One output channel of the clock generator.
//   refclk, rst        : clock, synchronous active-high reset
//   wr, wr_div, wr_phase, wr_en : accepted write for this channel (stages config)
//   load               : SETTLE->RUN pulse, staged config becomes active
//   run                : stays in RUN this cycle, advance the position counter
//   outclk, outclk_stb : registered divided clock and position-0 strobe
// The registered outputs always reflect the position the channel will hold in
// the following cycle, so the first RUN cycle already shows position P.
module nios_practica_clkdiv_chan
  import nios_practica_clk_pkg::*;
#(
  parameter int DIV_W       = CFG_DIV_W,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  input  logic             wr_en,
  input  logic             load,
  input  logic             run,
  output logic             outclk,
  output logic             outclk_stb
);

  chan_cfg_t        staged_reg;
  chan_cfg_t        active_reg;
  logic [DIV_W-1:0] pos_reg;
  logic             outclk_reg;
  logic             stb_reg;

  logic [DIV_W-1:0] pos_next;
  logic             active_live;
  logic             staged_live;
  logic             wr_clip;

  always_comb begin
    wr_clip     = (wr_phase >= wr_div);
    // N < 2 behaves exactly like a disabled channel
    active_live = active_reg.en && (active_reg.div >= DIV_W'(2));
    staged_live = staged_reg.en && (staged_reg.div >= DIV_W'(2));
    // wrap at N-1; only meaningful when the channel is live
    pos_next    = (pos_reg == active_reg.div - DIV_W'(1)) ? '0 : pos_reg + DIV_W'(1);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      staged_reg <= '{en: 1'b1, div: DIV_W'(DEFAULT_DIV), phase: '0};
      active_reg <= '{en: 1'b1, div: DIV_W'(DEFAULT_DIV), phase: '0};
      pos_reg    <= '0;
      outclk_reg <= 1'b0;
      stb_reg    <= 1'b0;
    end else begin
      if (wr) begin
        staged_reg.en    <= wr_en;
        staged_reg.div   <= wr_div;
        staged_reg.phase <= wr_clip ? '0 : wr_phase;
      end
      if (load) begin
        active_reg <= staged_reg;
        pos_reg    <= staged_reg.phase;
        outclk_reg <= staged_live && (staged_reg.phase < (staged_reg.div >> 1));
        stb_reg    <= staged_live && (staged_reg.phase == '0);
      end else if (run) begin
        pos_reg    <= pos_next;
        outclk_reg <= active_live && (pos_next < (active_reg.div >> 1));
        stb_reg    <= active_live && (pos_next == '0);
      end else begin
        outclk_reg <= 1'b0;
        stb_reg    <= 1'b0;
      end
    end
  end

  assign outclk     = outclk_reg;
  assign outclk_stb = stb_reg;

endmodule

// File: rtl/nios_practica_clkdiv_gen.sv
// Multi-channel fabric clock generator (refclk domain).
//   refclk, rst : sole clock, synchronous active-high reset
//   cfg         : configuration bus (slave side), see nios_practica_clkdiv_gen_if
//   outclk      : NUM_CLOCKS divided clocks, registered
//   outclk_stb  : NUM_CLOCKS one-cycle position-0 strobes, registered
//   locked      : high while running with stable, aligned outputs
// Any accepted write drops back to SETTLE; after LOCK_CYCLES quiet cycles all
// channels load their staged config together, so they share a common k.
module nios_practica_clkdiv_gen
  import nios_practica_clk_pkg::*;
#(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = CFG_DIV_W,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic                  refclk,
  input  logic                  rst,
  nios_practica_clkdiv_gen_if.slave cfg,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_stb,
  output logic                  locked
);

  localparam int          CNT_W     = $clog2(LOCK_CYCLES + 1);
  localparam logic [31:0] NUM_U     = NUM_CLOCKS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg;

  logic             sel_ok;
  logic             accept;
  logic             load;
  logic             run;

  always_comb begin
    sel_ok = (32'(cfg.cfg_sel) < NUM_U);
    accept = cfg.cfg_wr && sel_ok;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_SETTLE: begin
        if (accept) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (accept) begin
          state_next = ST_SETTLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_SETTLE;
        cnt_next   = '0;
      end
    endcase
    load = (state_reg == ST_SETTLE) && (state_next == ST_RUN);
    run  = (state_reg == ST_RUN) && (state_next == ST_RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg <= ST_SETTLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // a rejected select and a clipped phase report through the same pulse
      err_reg   <= cfg.cfg_wr && (!sel_ok || (cfg.cfg_phase >= cfg.cfg_div));
    end
  end

  assign cfg.cfg_err = err_reg;
  assign locked      = (state_reg == ST_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLOCKS; gi++) begin : g_chan
      logic wr_ch;
      assign wr_ch = accept && (32'(cfg.cfg_sel) == 32'(gi));

      nios_practica_clkdiv_chan #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV)
      ) u_chan (
        .refclk    (refclk),
        .rst       (rst),
        .wr        (wr_ch),
        .wr_div    (cfg.cfg_div),
        .wr_phase  (cfg.cfg_phase),
        .wr_en     (cfg.cfg_en),
        .load      (load),
        .run       (run),
        .outclk    (outclk[gi]),
        .outclk_stb(outclk_stb[gi])
      );
    end
  endgenerate

endmodule
